seq_frac_divider: RTL and testbench

- Iterative, parametrised unsigned restoring divider. Produces one quotient bit per clock.
- Output is a fixed-point quotient with WIDTH integer bits and FRAC fractional bits, plus the exact remainder and a divide-by-zero flag.
- Replaces our fully unrolled combinational divider array in timing-critical datapaths.
- Sits between a producer and consumer using valid/ready handshakes on both sides.

---
 rtl/seq_frac_divider.sv | 119 +++++++++++
 tb/tb_seq_frac_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_frac_divider.sv
// Iterative unsigned restoring divider with a fixed-point quotient:
// WIDTH integer bits and FRAC fractional bits, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | iterating, one quotient bit per cycle, MSB first
// DONE  | result held on the outputs until out_ready
module seq_frac_divider #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      dividend,
  input  logic [WIDTH-1:0]      divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH+FRAC-1:0] quotient,
  output logic [WIDTH-1:0]      remainder,
  output logic                  div_by_zero
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] part;
  logic [N-1:0]     q_work;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] part_next;
  logic [N-1:0]     q_next;

  // The trial value {P,b} is one bit wider than the divisor so a divisor with
  // its MSB set still compares correctly. Once the divisor has been subtracted
  // the result is below the divisor, so P itself fits back into WIDTH bits.
  // The dividend is shifted out MSB first; zeros shifted in supply the
  // fractional iterations.
  always_comb begin
    trial     = {part, dvd_sh[WIDTH-1]};
    fits      = trial >= {1'b0, dvs_q};
    diff      = trial[WIDTH-1:0] - dvs_q;
    part_next = fits ? diff : trial[WIDTH-1:0];
    q_next    = (q_work << 1) | N'(fits);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      part        <= '0;
      q_work      <= '0;
      dvd_sh      <= '0;
      dvs_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_sh   <= dividend;
            dvs_q    <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              part  <= '0;
              cnt   <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          part   <= part_next;
          q_work <= q_next;
          dvd_sh <= dvd_sh << 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient    <= q_next;
            remainder   <= part_next;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frac_divider.sv
// Bench for seq_frac_divider: a 32.8 instance with directed and random
// operands, and an 8.0 instance with random operands, against arithmetic models.
module tb_seq_frac_divider;

  logic clk;
  logic rst;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, div_by_zero_a;
  logic [31:0] dividend_a, divisor_a, remainder_a;
  logic [39:0] quotient_a;

  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, div_by_zero_b;
  logic [7:0] dividend_b, divisor_b, remainder_b, quotient_b;

  int checks = 0;
  int errors = 0;

  seq_frac_divider #(.WIDTH(32), .FRAC(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .dividend(dividend_a), .divisor(divisor_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .quotient(quotient_a), .remainder(remainder_a), .div_by_zero(div_by_zero_a)
  );

  seq_frac_divider #(.WIDTH(8), .FRAC(0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .dividend(dividend_b), .divisor(divisor_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .quotient(quotient_b), .remainder(remainder_b), .div_by_zero(div_by_zero_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient = floor(a*2^8/b), remainder = a*2^8 mod b.
  function automatic void model_a(input logic [31:0] a, input logic [31:0] b,
                                  output logic [39:0] q, output logic [31:0] r);
    logic [63:0] scaled;
    scaled = {32'd0, a} * 64'd256;
    if (b == 32'd0) begin
      q = {40{1'b1}};
      r = a;
    end else begin
      q = 40'(scaled / {32'd0, b});
      r = 32'(scaled % {32'd0, b});
    end
  endfunction

  task automatic op_a(input logic [31:0] a, input logic [31:0] b, input bit hs);
    logic [39:0] eq;
    logic [31:0] er;
    int lat;
    model_a(a, b, eq, er);
    chk("a_ready_before_accept", in_ready_a, 1'b1);
    in_valid_a = 1'b1;
    dividend_a = a;
    divisor_a  = b;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    dividend_a = $urandom;
    divisor_a  = $urandom;
    chk("a_ready_after_accept", in_ready_a, 1'b0);
    lat = 0;
    while (!out_valid_a && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("a_latency", lat, (b == 32'd0) ? 0 : 40);
    chk("a_quotient", quotient_a, eq);
    chk("a_remainder", remainder_a, er);
    chk("a_div_by_zero", div_by_zero_a, (b == 32'd0));
    chk("a_ready_in_done", in_ready_a, 1'b0);
    if (hs) begin
      out_ready_a = 1'b1;
      @(posedge clk); #1;
      out_ready_a = 1'b0;
      chk("a_idle_after_handshake", {out_valid_a, in_ready_a}, 2'b01);
    end
  endtask

  task automatic op_b(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    int lat;
    eq = (b == 8'd0) ? 8'hFF : a / b;
    er = (b == 8'd0) ? a : a % b;
    chk("b_ready_before_accept", in_ready_b, 1'b1);
    in_valid_b = 1'b1;
    dividend_b = a;
    divisor_b  = b;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    dividend_b = 8'($urandom);
    divisor_b  = 8'($urandom);
    lat = 0;
    while (!out_valid_b && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b_latency", lat, (b == 8'd0) ? 0 : 8);
    chk("b_result", {div_by_zero_b, quotient_b, remainder_b}, {(b == 8'd0), eq, er});
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    chk("b_idle_after_handshake", {out_valid_b, in_ready_b}, 2'b01);
  endtask

  initial begin
    logic [39:0] eq;
    logic [31:0] er;
    logic [31:0] ra, rb;

    rst = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; dividend_a = '0; divisor_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; dividend_b = '0; divisor_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("a_reset_state", {in_ready_a, out_valid_a, quotient_a, remainder_a, div_by_zero_a},
        {1'b1, 1'b0, 40'd0, 32'd0, 1'b0});
    chk("b_reset_state", {in_ready_b, out_valid_b, quotient_b, remainder_b, div_by_zero_b},
        {1'b1, 1'b0, 8'd0, 8'd0, 1'b0});

    op_a(32'd7, 32'd2, 1'b1);
    chk("q_7_div_2", {quotient_a, remainder_a}, {40'h0000000380, 32'd0});
    op_a(32'd1, 32'd3, 1'b1);
    chk("q_1_div_3", {quotient_a, remainder_a}, {40'h0000000055, 32'd1});
    op_a(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("q_max_div_max", {quotient_a, remainder_a}, {40'h0000000100, 32'd0});
    op_a(32'hFFFFFFFF, 32'h80000001, 1'b1);
    chk("q_max_div_big", quotient_a, 40'h00000001FF);
    op_a(32'd5, 32'd0, 1'b1);
    chk("dbz_5_div_0", {div_by_zero_a, quotient_a, remainder_a}, {1'b1, 40'hFFFFFFFFFF, 32'd5});
    op_a(32'd10, 32'd5, 1'b1);
    chk("after_dbz_10_div_5", {div_by_zero_a, quotient_a}, {1'b0, 40'h0000000200});

    // Stall in DONE with a new operand pulse that must be ignored.
    op_a(32'd123456, 32'd789, 1'b0);
    model_a(32'd123456, 32'd789, eq, er);
    for (int i = 0; i < 20; i++) begin
      in_valid_a = (i >= 5 && i < 8);
      dividend_a = 32'd999;
      divisor_a  = 32'd3;
      @(posedge clk); #1;
      chk("stall_hold", {out_valid_a, in_ready_a, div_by_zero_a, quotient_a, remainder_a},
          {1'b1, 1'b0, 1'b0, eq, er});
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    chk("stall_release", {out_valid_a, in_ready_a}, 2'b01);
    @(posedge clk); #1;
    chk("stall_pulse_not_captured", {out_valid_a, in_ready_a, quotient_a}, {1'b0, 1'b1, eq});

    // Reset in the middle of 100/7.
    in_valid_a = 1'b1;
    dividend_a = 32'd100;
    divisor_a  = 32'd7;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_op_reset", {in_ready_a, out_valid_a, quotient_a, remainder_a, div_by_zero_a},
        {1'b1, 1'b0, 40'd0, 32'd0, 1'b0});
    op_a(32'd100, 32'd7, 1'b1);
    chk("q_100_div_7", {quotient_a, remainder_a}, {40'h0000000E49, 32'd1});

    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = $urandom_range(1, 255); end
        2: begin ra = $urandom; rb = $urandom | 32'h80000000; end
        default: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 1000); end
      endcase
      if (rb == 32'd0) rb = 32'd1;
      op_a(ra, rb, 1'b1);
    end

    for (int n = 0; n < 800; n++) begin
      ra = $urandom;
      rb = $urandom_range(0, 15) == 0 ? 32'd0 : $urandom_range(1, 255);
      op_b(ra[7:0], rb[7:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
